// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - measures period and high time of a sampled clock-like input against expected values
// Optional idle timeout with stuck flag: define CLOCK_MONITOR_TIMEOUT_EN.
module clock_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int EXP_DUTY   = 50,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             period_err,
  output logic             duty_err,
  output logic             sticky_err,
  output logic             stuck
);

  localparam int                    EXP_HIGH     = (EXP_PERIOD * EXP_DUTY) / 100;
  localparam logic [CNT_W-1:0]      CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
  localparam logic signed [CNT_W:0] EXP_PERIOD_S = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] EXP_HIGH_S   = (CNT_W+1)'(EXP_HIGH);
  localparam logic signed [CNT_W:0] TOL_S        = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             meas_valid_q, meas_valid_d;
  logic             period_err_q, period_err_d;
  logic             duty_err_q, duty_err_d;
  logic             sticky_q, sticky_d;
  logic             stuck_rise;
  logic             rise;

`ifdef CLOCK_MONITOR_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              stuck_q, stuck_d;
`endif

  logic [CNT_W:0]        per_sum;
  logic [CNT_W-1:0]      per_val;
  logic                  per_force, hi_force;
  logic signed [CNT_W:0] per_diff, hi_diff, per_abs, hi_abs;
  logic                  per_err_c, duty_err_c;

  assign rise = s2_q & ~s3_q;

  // Measurement of the period that ends at the current rising edge.
  always_comb begin
    per_sum    = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
    per_val    = per_sum[CNT_W] ? CNT_MAX : per_sum[CNT_W-1:0];
    hi_force   = (hi_cnt_q == CNT_MAX);
    per_force  = per_sum[CNT_W] | hi_force | (lo_cnt_q == CNT_MAX);
    per_diff   = $signed({1'b0, per_val}) - EXP_PERIOD_S;
    hi_diff    = $signed({1'b0, hi_cnt_q}) - EXP_HIGH_S;
    per_abs    = per_diff[CNT_W] ? -per_diff : per_diff;
    hi_abs     = hi_diff[CNT_W] ? -hi_diff : hi_diff;
    per_err_c  = per_force | (per_abs > TOL_S);
    duty_err_c = hi_force | (hi_abs > TOL_S);
  end

  always_comb begin
    s1_d         = mon_in;
    s2_d         = s1_q;
    s3_d         = s2_q;
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    period_err_d = period_err_q;
    duty_err_d   = duty_err_q;
    meas_valid_d = 1'b0;
    stuck_rise   = 1'b0;
`ifdef CLOCK_MONITOR_TIMEOUT_EN
    idle_cnt_d   = idle_cnt_q;
    stuck_d      = stuck_q;
`endif

    if (!en) begin
      state_d  = ST_IDLE;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hi_cnt_d = '0;
          lo_cnt_d = '0;
          state_d  = ST_ARM;
        end
        ST_ARM: begin
          if (rise) begin
            hi_cnt_d = CNT_ONE;
            lo_cnt_d = '0;
            state_d  = ST_MEAS;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            period_d     = per_val;
            high_d       = hi_cnt_q;
            period_err_d = per_err_c;
            duty_err_d   = duty_err_c;
            meas_valid_d = 1'b1;
            hi_cnt_d     = CNT_ONE;
            lo_cnt_d     = '0;
          end else if (s2_q) begin
            if (hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + CNT_ONE;
          end else begin
            if (lo_cnt_q != CNT_MAX) lo_cnt_d = lo_cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef CLOCK_MONITOR_TIMEOUT_EN
    // A timeout abandons the period in progress and re-arms.
    if (!en || state_q == ST_IDLE) begin
      idle_cnt_d = '0;
      if (!en) stuck_d = 1'b0;
    end else if (rise) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
      idle_cnt_d = '0;
      stuck_d    = 1'b1;
      state_d    = ST_ARM;
      hi_cnt_d   = '0;
      lo_cnt_d   = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    if (en && rise) stuck_d = 1'b0;
    stuck_rise = stuck_d & ~stuck_q;
`endif

    // A new error outranks a clear arriving in the same cycle.
    sticky_d = sticky_q;
    if (err_clr) sticky_d = 1'b0;
    if ((meas_valid_d & (per_err_c | duty_err_c)) | stuck_rise) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      duty_err_q   <= 1'b0;
      sticky_q     <= 1'b0;
`ifdef CLOCK_MONITOR_TIMEOUT_EN
      idle_cnt_q   <= '0;
      stuck_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      period_err_q <= period_err_d;
      duty_err_q   <= duty_err_d;
      sticky_q     <= sticky_d;
`ifdef CLOCK_MONITOR_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
      stuck_q      <= stuck_d;
`endif
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign period_err = period_err_q;
  assign duty_err   = duty_err_q;
  assign sticky_err = sticky_q;
`ifdef CLOCK_MONITOR_TIMEOUT_EN
  assign stuck      = stuck_q;
`else
  assign stuck      = 1'b0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - randomized self-checking bench for clock_monitor
module tb_clock_monitor;

  localparam int CNT_W      = 16;
  localparam int EXP_PERIOD = 10;
  localparam int EXP_DUTY   = 50;
  localparam int TOL        = 1;
  localparam int TIMEOUT    = 64;
  localparam int EXP_HIGH   = (EXP_PERIOD * EXP_DUTY) / 100;
`ifdef CLOCK_MONITOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, en, mon_in, err_clr;
  logic [CNT_W-1:0] period_out, high_out;
  logic             meas_valid, period_err, duty_err, sticky_err, stuck;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  typedef struct {
    int per;
    int hi;
    int pe;
    int de;
    int cyc;
  } meas_t;

  meas_t got_q[$];
  meas_t exp_q[$];

  // Reference model: each rising edge seen while enabled and already armed
  // reports the complete period that just ended.
  bit have_prev;
  bit en_m;
  bit sticky_m;
  int prev_h, prev_l;

  clock_monitor #(
    .CNT_W     (CNT_W),
    .EXP_PERIOD(EXP_PERIOD),
    .EXP_DUTY  (EXP_DUTY),
    .TOL       (TOL),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mon_in    (mon_in),
    .err_clr   (err_clr),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .period_err(period_err),
    .duty_err  (duty_err),
    .sticky_err(sticky_err),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    meas_t m;
    #1;
    if (meas_valid === 1'b1) begin
      m.per = int'(period_out);
      m.hi  = int'(high_out);
      m.pe  = int'(period_err);
      m.de  = int'(duty_err);
      m.cyc = cyc_cnt;
      got_q.push_back(m);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic meas_t model_meas(input int h, input int l, input int c);
    meas_t m;
    m.per = h + l;
    m.hi  = h;
    m.pe  = (iabs(h + l - EXP_PERIOD) > TOL) ? 1 : 0;
    m.de  = (iabs(h - EXP_HIGH) > TOL) ? 1 : 0;
    m.cyc = c;
    return m;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    if (have_prev) prev_l += n;
  endtask

  task automatic set_en(input bit b);
    en   = b;
    en_m = b;
    if (!b) have_prev = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr  = 1'b0;
    sticky_m = 1'b0;
    if (have_prev) prev_l += 1;
  endtask

  // One mon_in period: h cycles high then l low; drop_at>0 disables after that many high cycles.
  task automatic drive_period(input int h, input int l, input int drop_at);
    meas_t m;
    if (have_prev && en_m) begin
      m = model_meas(prev_h, prev_l, cyc_cnt + 3);
      exp_q.push_back(m);
      if (m.pe != 0 || m.de != 0) sticky_m = 1'b1;
    end
    have_prev = en_m;
    prev_h    = h;
    prev_l    = l;
    mon_in    = 1'b1;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      if (drop_at != 0 && i + 1 == drop_at) set_en(1'b0);
    end
    mon_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic compare_meas(input string tag);
    check_eq({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq({tag, ".period"}, got_q[i].per, exp_q[i].per);
      check_eq({tag, ".high"}, got_q[i].hi, exp_q[i].hi);
      check_eq({tag, ".period_err"}, got_q[i].pe, exp_q[i].pe);
      check_eq({tag, ".duty_err"}, got_q[i].de, exp_q[i].de);
      check_eq({tag, ".latency"}, got_q[i].cyc, exp_q[i].cyc);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".period_out"}, period_out, 0);
    check_eq({tag, ".high_out"}, high_out, 0);
    check_eq({tag, ".meas_valid"}, meas_valid, 0);
    check_eq({tag, ".period_err"}, period_err, 0);
    check_eq({tag, ".duty_err"}, duty_err, 0);
    check_eq({tag, ".sticky_err"}, sticky_err, 0);
    check_eq({tag, ".stuck"}, stuck, 0);
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    mon_in    = 1'b0;
    err_clr   = 1'b0;
    have_prev = 1'b0;
    en_m      = 1'b0;
    sticky_m  = 1'b0;
    prev_h    = 0;
    prev_l    = 0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Nominal 50% clock
    set_en(1'b1);
    cycles(2);
    repeat (5) drive_period(5, 5, 0);
    cycles(4);
    compare_meas("duty50");
    check_eq("duty50.sticky", sticky_err, sticky_m);

    // Period out of tolerance, then clear, then period 11
    repeat (4) drive_period(6, 7, 0);
    cycles(4);
    compare_meas("per13");
    check_eq("per13.sticky", sticky_err, sticky_m);
    pulse_clr();
    check_eq("per13.clr", sticky_err, sticky_m);
    repeat (4) drive_period(5, 6, 0);
    cycles(4);
    compare_meas("per11");

    // Duty out of tolerance, then within tolerance
    repeat (3) drive_period(8, 2, 0);
    repeat (3) drive_period(6, 4, 0);
    cycles(4);
    compare_meas("duty");
    check_eq("duty.sticky", sticky_err, sticky_m);

    // Enable dropped mid-period
    pulse_clr();
    repeat (3) drive_period(5, 5, 0);
    drive_period(5, 5, 3);
    repeat (2) drive_period(5, 5, 0);
    cycles(4);
    compare_meas("en_drop");
    check_eq("en_drop.hold", period_out, EXP_PERIOD);
    set_en(1'b1);
    cycles(2);
    repeat (3) drive_period(5, 5, 0);
    cycles(4);
    compare_meas("reenable");

    // Asynchronous reset while period_err is set
    repeat (3) drive_period(6, 7, 0);
    cycles(4);
    compare_meas("pre_rst");
    check_eq("pre_rst.period_err", period_err, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    have_prev = 1'b0;
    sticky_m  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    repeat (3) drive_period(5, 5, 0);
    cycles(4);
    compare_meas("post_rst");

    // Random periods around the tolerance window
    for (int b = 0; b < 4; b++) begin
      pulse_clr();
      repeat (8) drive_period(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 0);
      cycles(4);
      compare_meas("rand");
      check_eq("rand.sticky", sticky_err, sticky_m);
    end

    // mon_in held high after enable
    set_en(1'b0);
    mon_in = 1'b1;
    cycles(4);
    pulse_clr();
    en   = 1'b1;
    en_m = 1'b1;
    repeat (TIMEOUT) @(posedge clk);
    #1;
    check_eq("held.stuck_before", stuck, 0);
    check_eq("held.sticky_before", sticky_err, 0);
    @(posedge clk);
    #1;
    check_eq("held.stuck", stuck, TO_EN);
    check_eq("held.sticky", sticky_err, TO_EN);
    sticky_m = TO_EN;
    repeat (4) @(negedge clk);
    mon_in = 1'b0;
    cycles(5);
    drive_period(5, 5, 0);
    check_eq("resume.stuck", stuck, 0);
    repeat (2) drive_period(5, 5, 0);
    cycles(4);
    compare_meas("resume");
    check_eq("resume.sticky", sticky_err, sticky_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Synthesizable receive-side counterpart of the bench clock generator.
- Samples an externally generated clock-like signal (mon_in) on the system clock.
- Measures the period and high time of mon_in in clk cycles and checks both against the expected PERIOD/DUTY_CYCLE within a tolerance.
- Used in benches and on-chip to confirm that a generated clock meets spec.

Parameters:
- CNT_W, 16, width of the measurement counters and outputs.
- EXP_PERIOD, 10, expected mon_in period in clk cycles.
- EXP_DUTY, 50, expected duty cycle in percent; expected high time EXP_HIGH = (EXP_PERIOD*EXP_DUTY)/100, integer truncation.
- TOL, 1, allowed absolute deviation in clk cycles for both period and high time.
- TIMEOUT, 1024, clk cycles without a rising edge before stuck asserts (optional feature only).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  monitor enable.
- mon_in  in  1  asynchronous monitored clock.
- err_clr  in  1  one-cycle pulse; clears sticky_err.
- period_out  out  CNT_W  last measured period.
- high_out  out  CNT_W  last measured high time.
- meas_valid  out  1  one-cycle pulse when the outputs update.
- period_err  out  1  last period out of tolerance.
- duty_err  out  1  last high time out of tolerance.
- sticky_err  out  1  OR of all errors since the last clear.
- stuck  out  1  no edge within TIMEOUT (optional feature).

Behaviour:
- Reset (rst=0, async) clears every register: all outputs 0, FSM state IDLE, sync flops 0.
- Synchronizer:
  - mon_in passes through 2 flops (s1, s2); s3 is s2 delayed by one cycle.
  - A rising edge is detected in any cycle with s2=1 and s3=0.
  - All counting uses s2.
- FSM IDLE:
  - Counters hold 0; meas_valid=0.
  - en=1 -> ARM.
- FSM ARM:
  - Waits for the first rising edge; no measurement is made, which discards the partial first period.
  - On the edge: hi_cnt=1, lo_cnt=0 -> MEAS.
- FSM MEAS:
  - Each cycle without an edge: hi_cnt+1 if s2=1, else lo_cnt+1. Both counters saturate at 2^CNT_W-1.
  - On a rising edge:
    - period_out = hi_cnt+lo_cnt, saturating.
    - high_out = hi_cnt.
    - Error flags computed from these same values.
    - meas_valid pulses high for exactly one cycle.
    - Counters reload to hi=1, lo=0.
- Output latency: outputs and meas_valid are registered and update on the clk edge that ends the edge-detect cycle, i.e. 3 clk edges after mon_in is first sampled high.
- Error rules:
  - period_err = |period_out - EXP_PERIOD| > TOL.
  - duty_err = |high_out - EXP_HIGH| > TOL.
  - Differences use CNT_W+1 bit signed arithmetic.
  - A saturated counter always forces the corresponding error to 1.
  - Both flags are re-evaluated at every measurement, not sticky.
- sticky_err:
  - Set on any meas_valid cycle carrying period_err|duty_err, or on stuck rising.
  - Cleared by err_clr.
  - If a set and err_clr occur in the same cycle, set wins.
- en=0 in any state:
  - Next cycle goes to IDLE; counters clear; meas_valid forced 0.
  - period_out/high_out/error flags hold their last values.
  - Re-enable restarts from ARM.
- The sync flops run regardless of en.

Optional Feature:
- Macro: CLOCK_MONITOR_TIMEOUT_EN.
- Defined:
  - An idle counter runs in ARM/MEAS and clears on every rising edge.
  - When it reaches TIMEOUT: stuck=1, sticky_err set, FSM returns to ARM.
  - stuck clears on the next detected rising edge or en=0.
- Not defined:
  - No idle counter; stuck tied 0.
  - A stuck input shows up only as saturated counters and an error at the next edge.

Test Plan:
- 50% clock: mon_in period 10 clk, high 5, 5 periods after en -> first period discarded; then 4 meas_valid pulses, each with period_out=10, high_out=5, no errors.
- Period out of tolerance: mon_in period 13, high 6 -> period_out=13, period_err=1, duty_err=0, sticky_err=1. Then err_clr -> sticky_err=0. Then period 11, high 5 -> period_err=0.
- Duty out of tolerance: period 10, high 8 -> duty_err=1, period_err=0. Period 10, high 6 -> both 0 (within TOL).
- en dropped mid-period: outputs hold (period_out=10); meas_valid stays 0. Re-enable -> first meas_valid only after two rising edges.
- Reset mid-measurement: rst=0 asynchronously with period_err=1 -> all outputs 0 immediately, with no clk edge needed. Release -> IDLE.
- Macro defined, TIMEOUT=64: mon_in held high after enable -> stuck=1 and sticky_err=1 exactly at the 64th idle cycle. Resume toggling -> stuck=0 on the first edge; a measurement follows after the second edge.
